// File: rtl/pe_ctrl_pkg.sv
// Shared types and default sizing for the PE-chain sequencer.
package pe_ctrl_pkg;

  localparam int LAT_DEF        = 4;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int LEN_W_DEF      = 16;
  localparam int ELEM_W         = 8;
  localparam int PSUM_W         = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FLUSH  = 3'd1,
    ST_STREAM = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/pe_chain_ctrl_if.sv
// Job, source, PE-chain and sink signals of the sequencer; master drives jobs/data, slave is the controller.
interface pe_chain_ctrl_if import pe_ctrl_pkg::*; #(
  parameter int LEN_W = LEN_W_DEF
);
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              done;
  logic              in_valid;
  logic              in_ready;
  logic [ELEM_W-1:0] in_data;
  logic [ELEM_W-1:0] pe_elem;
  logic              pe_clear_n;
  logic [PSUM_W-1:0] pe_psum;
  logic              out_valid;
  logic              out_ready;
  logic [PSUM_W-1:0] out_data;

  modport master (
    output start, len, in_valid, in_data, pe_psum, out_ready,
    input  busy, done, in_ready, pe_elem, pe_clear_n, out_valid, out_data
  );

  modport slave (
    input  start, len, in_valid, in_data, pe_psum, out_ready,
    output busy, done, in_ready, pe_elem, pe_clear_n, out_valid, out_data
  );
endinterface

// File: rtl/result_fifo.sv
// Synchronous result FIFO with async clear; simultaneous push and pop are both honoured, even when full.
module result_fifo import pe_ctrl_pkg::*; #(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int W     = PSUM_W
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_s, do_push_s, do_pop_s;

  always_comb begin
    full_s    = (count_q == CW'(DEPTH));
    do_pop_s  = pop & (count_q != '0);
    do_push_s = push & (~full_s | do_pop_s);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

  result_fifo_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk   (clk),
    .clear (clear),
    .push  (push),
    .pop   (do_pop_s),
    .count (count_q)
  );
endmodule

// File: rtl/result_fifo_chk.sv
// Overflow watchdog for result_fifo: a push into a full FIFO is only legal alongside a pop.
module result_fifo_chk #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input logic          clk,
  input logic          clear,
  input logic          push,
  input logic          pop,
  input logic [CW-1:0] count
);
  a_no_overflow: assert property (@(posedge clk) disable iff (clear)
    !(push && !pop && (count == CW'(DEPTH))));
endmodule

// File: rtl/pe_chain_ctrl.sv
// Credit-gated sequencer for a stall-free PE chain: issues elements, tracks live slots,
// and catches tail pSums into a result FIFO.
module pe_chain_ctrl import pe_ctrl_pkg::*; #(
  parameter int LAT        = LAT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int LEN_W      = LEN_W_DEF
) (
  input logic             clk,
  input logic             clear,
  pe_chain_ctrl_if.slave  bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = $clog2(LAT + 1);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] issued_q, issued_d;
  logic [LAT-1:0]   vpipe_q, vpipe_d;
  logic [IW-1:0]    inflight_q, inflight_d;
  logic             pe_clear_n_q, pe_clear_n_d;

  logic [CW-1:0]    fifo_count_s, credit_sum_s;
  logic             fifo_empty_s, credit_s, in_ready_s, issue_s, push_s, pop_s;

  // A result may only be launched if its FIFO slot is already reserved.
  always_comb begin
    credit_sum_s = fifo_count_s + CW'(inflight_q);
    credit_s     = (credit_sum_s < CW'(FIFO_DEPTH));
    in_ready_s   = (state_q == ST_STREAM) & credit_s;
    issue_s      = in_ready_s & bus.in_valid;
    push_s       = vpipe_q[LAT-1];
    pop_s        = ~fifo_empty_s & bus.out_ready;
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    issued_d     = issued_q;
    vpipe_d      = {vpipe_q[LAT-2:0], issue_s};
    inflight_d   = inflight_q;
    pe_clear_n_d = pe_clear_n_q;
    case ({issue_s, push_s})
      2'b10:   inflight_d = inflight_q + IW'(1);
      2'b01:   inflight_d = inflight_q - IW'(1);
      default: inflight_d = inflight_q;
    endcase
    if (issue_s) begin
      issued_d = issued_q + LEN_W'(1);
    end else begin
      issued_d = issued_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          len_d   = bus.len;
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        vpipe_d    = '0;
        inflight_d = '0;
        issued_d   = '0;
        state_d    = (len_q != '0) ? ST_STREAM : ST_WAIT;
      end
      ST_STREAM: begin
        if (issue_s && (issued_q + LEN_W'(1) == len_q)) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_WAIT: begin
        if ((inflight_q == '0) && fifo_empty_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // The chain stays cleared from reset until the first flush has completed.
    if (state_d == ST_FLUSH) begin
      pe_clear_n_d = 1'b0;
    end else if (state_q == ST_FLUSH) begin
      pe_clear_n_d = 1'b1;
    end else begin
      pe_clear_n_d = pe_clear_n_q;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      issued_q     <= '0;
      vpipe_q      <= '0;
      inflight_q   <= '0;
      pe_clear_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      issued_q     <= issued_d;
      vpipe_q      <= vpipe_d;
      inflight_q   <= inflight_d;
      pe_clear_n_q <= pe_clear_n_d;
    end
  end

  result_fifo #(.DEPTH(FIFO_DEPTH), .W(PSUM_W)) u_fifo (
    .clk   (clk),
    .clear (clear),
    .push  (push_s),
    .wdata (bus.pe_psum),
    .pop   (pop_s),
    .rdata (bus.out_data),
    .count (fifo_count_s),
    .empty (fifo_empty_s)
  );

  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.in_ready   = in_ready_s;
  assign bus.pe_elem    = issue_s ? bus.in_data : ELEM_W'(0);
  assign bus.pe_clear_n = pe_clear_n_q;
  assign bus.out_valid  = ~fifo_empty_s;
endmodule

// File: tb/tb_pe_chain_ctrl.sv
// Directed + randomized bench: a 4-PE unit-weight chain model feeds pe_psum, and a queue of 4*elem
// values is the expected result stream.
module tb_pe_chain_ctrl;
  logic clk = 1'b0;
  logic clear = 1'b1;
  always #5 clk = ~clk;

  pe_chain_ctrl_if ifc ();
  pe_chain_ctrl u_dut (.clk(clk), .clear(clear), .bus(ifc));

  // PE chain environment: weight 1 everywhere, PE0 pSum input tied to zero.
  logic [7:0]  x_r [4];
  logic [15:0] p_r [4];
  always @(posedge clk) begin
    if (!ifc.pe_clear_n) begin
      for (int k = 0; k < 4; k++) begin x_r[k] <= 8'd0; p_r[k] <= 16'd0; end
    end else begin
      x_r[0] <= ifc.pe_elem;
      p_r[0] <= 16'(ifc.pe_elem);
      for (int k = 1; k < 4; k++) begin
        x_r[k] <= x_r[k-1];
        p_r[k] <= p_r[k-1] + 16'(x_r[k-1]);
      end
    end
  end
  assign ifc.pe_psum = p_r[3];

  int total = 0, bad = 0;
  int cyc = 0, acc = 0, n_out = 0, done_cnt = 0, busy_cyc = 0, job_len = 0;
  int first_acc = -1, last_acc = -1, first_ov = -1, last_ov = -1, done_cyc = -1;
  logic [15:0] last_out;
  logic [15:0] expq[$];
  logic [7:0]  src[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!ifc.busy || acc >= job_len || (acc - n_out) >= 8) check("in_ready_gate", ifc.in_ready, 0);
    check("pe_elem", ifc.pe_elem, (ifc.in_valid && ifc.in_ready) ? ifc.in_data : 8'd0);
    if (ifc.in_valid && ifc.in_ready) begin
      expq.push_back(16'(ifc.in_data) * 16'd4);
      acc++;
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
    end
    if (ifc.out_valid) begin
      if (first_ov < 0) first_ov = cyc;
      last_ov = cyc;
    end
    if (ifc.out_valid && ifc.out_ready) begin
      check("out_expected", int'(expq.size() != 0), 1);
      if (expq.size() != 0) check("out_data", ifc.out_data, expq.pop_front());
      last_out = ifc.out_data;
      n_out++;
    end
    if (ifc.done) begin done_cnt++; done_cyc = cyc; end
    if (ifc.busy) busy_cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_stats();
    acc = 0; n_out = 0; done_cnt = 0; busy_cyc = 0;
    first_acc = -1; last_acc = -1; first_ov = -1; last_ov = -1; done_cyc = -1;
    expq.delete();
  endtask

  // vmode: 0 always valid, 1 every other cycle, 2 random; rmode: 0 always ready, 2 random.
  task automatic run_job(input int n, input int vmode, input int rmode, input int hold, input int mid_start);
    reset_stats();
    job_len = n;
    ifc.start = 1'b1; ifc.len = 16'(n); ifc.in_valid = 1'b0; ifc.out_ready = 1'b1;
    tick();
    ifc.start = 1'b0;
    for (int k = 0; k < 400 && done_cnt == 0; k++) begin
      ifc.in_valid = (acc < src.size()) &&
                     (vmode == 0 || (vmode == 1 && k % 2 == 0) || (vmode == 2 && $urandom_range(0, 99) < 65));
      ifc.in_data  = ifc.in_valid ? src[acc] : 8'($urandom);
      ifc.out_ready = (k < hold) ? 1'b0 : ((rmode == 0) ? 1'b1 : 1'($urandom));
      if (k == mid_start) begin ifc.start = 1'b1; ifc.len = 16'(n + 7); end
      else ifc.start = 1'b0;
      if (hold > 0 && k == hold) begin
        check("bp_accepted", acc, 8);
        check("bp_in_ready", ifc.in_ready, 0);
      end
      tick();
    end
    ifc.in_valid = 1'b0; ifc.start = 1'b0; ifc.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    check("done_pulses", done_cnt, 1);
    check("accepted", acc, n);
    check("delivered", n_out, n);
    check("leftover", expq.size(), 0);
    check("idle_clear_n", ifc.pe_clear_n, 1);
  endtask

  initial begin
    ifc.start = 1'b0; ifc.len = 16'd0; ifc.in_valid = 1'b0; ifc.in_data = 8'd0; ifc.out_ready = 1'b1;
    job_len = 0;
    #1;
    check("rst_busy", ifc.busy, 0);
    check("rst_done", ifc.done, 0);
    check("rst_in_ready", ifc.in_ready, 0);
    check("rst_clear_n", ifc.pe_clear_n, 0);
    check("rst_out_valid", ifc.out_valid, 0);
    repeat (2) @(posedge clk);
    #1 clear = 1'b0;
    repeat (3) tick();
    check("pre_flush_clear_n", ifc.pe_clear_n, 0);

    // Basic stream with latency and completion timing.
    src = '{8'd1, 8'd2, 8'd3};
    run_job(3, 0, 0, 0, -1);
    check("first_out_latency", first_ov - first_acc, 5);
    check("done_after_empty", done_cyc - last_ov, 2);

    // Source bubbles.
    src = '{8'd5, 8'd6, 8'd7, 8'd8};
    run_job(4, 1, 0, 0, -1);

    // Backpressure: sink stalled for 20 cycles.
    src.delete();
    for (int i = 0; i < 12; i++) src.push_back(8'($urandom));
    run_job(12, 0, 0, 20, -1);

    // Empty job.
    src.delete();
    run_job(0, 0, 0, 0, -1);
    check("len0_busy_cycles", busy_cyc, 3);

    // Sustained throughput.
    src.delete();
    for (int i = 0; i < 16; i++) src.push_back(8'($urandom));
    run_job(16, 0, 0, 0, -1);
    check("throughput", last_acc - first_acc, 15);

    // start pulse while streaming must be ignored.
    src.delete();
    for (int i = 0; i < 5; i++) src.push_back(8'($urandom));
    run_job(5, 1, 0, 0, 2);

    // Mid-job clear.
    reset_stats();
    src = '{8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16};
    job_len = 6;
    ifc.start = 1'b1; ifc.len = 16'd6;
    tick();
    ifc.start = 1'b0;
    for (int k = 0; k < 50 && acc < 2; k++) begin
      ifc.in_valid = 1'b1; ifc.in_data = src[acc];
      tick();
    end
    check("pre_clear_issues", acc, 2);
    ifc.in_valid = 1'b0;
    clear = 1'b1;
    #1;
    check("clr_out_valid", ifc.out_valid, 0);
    check("clr_busy", ifc.busy, 0);
    check("clr_clear_n", ifc.pe_clear_n, 0);
    expq.delete();
    done_cnt = 0;
    job_len = 0;
    tick();
    clear = 1'b0;
    repeat (6) tick();
    check("clr_no_done", done_cnt, 0);
    check("clr_no_output", ifc.out_valid, 0);
    src = '{8'd9};
    run_job(1, 0, 0, 0, -1);
    check("post_clear_result", last_out, 36);

    // Randomized source and sink.
    src.delete();
    for (int i = 0; i < 30; i++) src.push_back(8'($urandom));
    run_job(30, 2, 2, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pe_chain_ctrl.md
Name: pe_chain_ctrl

Overview:
- Sequencer for a 1-D chain of NUM_PE weight-stationary PEs: accepts a job of LEN 8-bit elements, feeds them into PE0, and injects zero bubbles when the source stalls.
- Tracks which chain slots carry real data, captures the matching 16-bit partial sums at the chain tail, and buffers them in a result FIFO behind a valid/ready sink.
- The PE chain has no stall input, so issue is credit-gated: a result is only launched if FIFO space is guaranteed for it.

Parameters:
- LAT, 4, chain latency in cycles (= NUM_PE); element issued in cycle t yields its pSum on pe_psum in cycle t+LAT
- FIFO_DEPTH, 8, result FIFO entries (power of two, ≥2)
- LEN_W, 16, width of job length

Ports:
- clk  in  1  clock, rising edge
- clear  in  1  asynchronous, active-high reset
- start  in  1  job start pulse, honoured only in IDLE
- len  in  LEN_W  element count, sampled on accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job completion
- in_valid  in  1  source element valid
- in_ready  out  1  controller accepts in_data this cycle
- in_data  in  8  source element
- pe_elem  out  8  element to PE0 (in_data on issue, else 0)
- pe_clear_n  out  1  active-low clear to the PE chain
- pe_psum  in  16  pSum from last PE
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  sink accepts out_data
- out_data  out  16  FIFO head

Behaviour:
- Reset (clear=1, async): state IDLE; busy=0, done=0, in_ready=0, pe_clear_n=0, out_valid=0; FIFO emptied; valid pipe, counters and credits zeroed.
- After reset release, pe_clear_n stays 0 until the first FLUSH completes, so the chain holds zeros.
- FSM states:
  - IDLE: start=1 → latch len, go to FLUSH. start in any other state is ignored.
  - FLUSH (1 cycle): pe_clear_n=0, valid pipe cleared. Next state STREAM if len≠0, else WAIT.
  - STREAM: pe_clear_n=1.
    - issue = in_valid & (fifo_count + inflight < FIFO_DEPTH).
    - in_ready = the credit term only, independent of in_valid.
    - On issue: pe_elem=in_data, vpipe[0]=1, issued++. Otherwise pe_elem=0, vpipe[0]=0.
    - Go to WAIT in the cycle after issued reaches len.
  - WAIT: pe_clear_n=1, no issue, pe_elem=0. When inflight==0 and the FIFO is empty → DONE.
  - DONE (1 cycle): done=1 → IDLE.
- Valid pipe: LAT-bit shift register, advanced every cycle. Its tail bit aligns with pe_psum in the same cycle. When the tail bit is 1, pe_psum is pushed into the FIFO.
- inflight = popcount of the valid pipe, kept as a counter: +1 on issue, −1 on tail push, unchanged when both happen.
- FIFO:
  - Push and pop in the same cycle are both performed, including when full.
  - The credit check guarantees a push never finds the FIFO full; overflow is an assertion failure.
  - Pop when out_valid & out_ready.
- out_data is the registered FIFO head; zero latency from write to visibility is not required (1 cycle).
- Arithmetic: counters are LEN_W bits, with no wrap within a job. The fifo_count+inflight compare is done one bit wider than clog2(FIFO_DEPTH).
- clear asserted mid-job: all in-flight and buffered results are discarded and the PE chain is cleared. No done pulse is produced.
- Sustained throughput: 1 element/cycle while the sink drains 1/cycle.

Decomposition:
- Shared package/header pe_ctrl_pkg: state encodings (IDLE, FLUSH, STREAM, WAIT, DONE), default LAT, FIFO_DEPTH, and data widths 8/16.
- One sub-module, result_fifo: synchronous FIFO, async active-high clear, parameters DEPTH and W=16, with count output.

Test Plan:
Bench model: 4 PEs, weight 1, PE0 pSum_in tied to 0, LAT=4, so result = 4×elem.
- Basic stream: len=3, elems 1,2,3 back-to-back, out_ready=1 → out_data 4,8,12 in order; first out_valid 5 cycles after first issue; done one cycle after FIFO empties.
- Source bubbles: len=4, in_valid deasserted every other cycle, elems 5,6,7,8 → pe_elem=0 on gaps; outputs exactly 20,24,28,32 with no spurious pushes.
- Backpressure: len=12, out_ready=0 → in_ready drops after 8 issues; no overflow. Release out_ready → all 12 results delivered in order, then done.
- len=0 → FLUSH, WAIT, DONE; done pulses; no outputs; busy high 3 cycles.
- Mid-job clear: assert clear after 2 issues of len=6 → out_valid=0, busy=0, pe_clear_n=0 immediately. A new start with len=1, elem 9 → single output 36.
- start while busy (pulse in STREAM) → ignored; len unchanged; exactly one done.
